// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multicycle main controller for the ARM-subset datapath.
//               Sequences fetch/decode/execute/writeback, evaluates condition
//               codes against an internal flag register and runs multi-cycle
//               FPU operations through a start/done handshake with timeout.
//               Optional macro COND_EXEC_EN enables conditional execution;
//               when undefined every instruction executes unconditionally.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller #(
    parameter int FP_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        fp_done,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        WE4,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  ALUControl,
    output logic [1:0]  FPControl,
    output logic        ResultControl,
    output logic        NewSource,
    output logic        IsMul,
    output logic        fp_start,
    output logic        fp_err,
    output logic [3:0]  Flags
);

    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_FETCH   = 5'd1,
        S_DECODE  = 5'd2,
        S_MEMADR  = 5'd3,
        S_MEMRD   = 5'd4,
        S_MEMWB   = 5'd5,
        S_MEMWR   = 5'd6,
        S_EXECR   = 5'd7,
        S_EXECI   = 5'd8,
        S_ALUWB   = 5'd9,
        S_MULEX   = 5'd10,
        S_MULWB   = 5'd11,
        S_FPSTART = 5'd12,
        S_FPWAIT  = 5'd13,
        S_FPWB    = 5'd14,
        S_BRANCH  = 5'd15
    } state_t;

    localparam logic [7:0] C_FP_LIMIT = 8'(FP_TIMEOUT);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;
    logic [7:0] r_fpcnt;
    logic       w_condex;
    logic       w_flag_we;
    logic       w_fp_hit;
    logic [3:0] w_dpctl;
    logic       w_unused;

    // Instruction bits consumed elsewhere in the datapath, not by control
`ifdef COND_EXEC_EN
    assign w_unused = ^{Instr[19:16], Instr[11:8], Instr[3:0]};
`else
    assign w_unused = ^{Instr[31:28], Instr[19:16], Instr[11:8], Instr[3:0]};
`endif

    assign Flags     = r_flags;
    assign w_fp_hit  = ((r_fpcnt + 8'd1) == C_FP_LIMIT);
    assign w_flag_we = ((r_state == S_EXECR) || (r_state == S_EXECI)) && Instr[20] && w_condex;

    // Condition-code evaluation against the architectural flags {N,Z,C,V}
    always_comb begin
`ifdef COND_EXEC_EN
        case (Instr[31:28])
            4'b0000: w_condex = r_flags[2];
            4'b0001: w_condex = ~r_flags[2];
            4'b0010: w_condex = r_flags[1];
            4'b0011: w_condex = ~r_flags[1];
            4'b0100: w_condex = r_flags[3];
            4'b0101: w_condex = ~r_flags[3];
            4'b0110: w_condex = r_flags[0];
            4'b0111: w_condex = ~r_flags[0];
            4'b1000: w_condex = r_flags[1] & ~r_flags[2];
            4'b1001: w_condex = ~r_flags[1] | r_flags[2];
            4'b1010: w_condex = (r_flags[3] == r_flags[0]);
            4'b1011: w_condex = (r_flags[3] != r_flags[0]);
            4'b1100: w_condex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_condex = r_flags[2] | (r_flags[3] != r_flags[0]);
            default: w_condex = 1'b1;  // AL, and 1111 treated as AL
        endcase
`else
        w_condex = 1'b1;
`endif
    end

    // Data-processing opcode to ALU operation; unknown opcodes fall back to ADD
    always_comb begin
        case (Instr[24:21])
            4'b0100: w_dpctl = 4'b0000;
            4'b0010: w_dpctl = 4'b0001;
            4'b0000: w_dpctl = 4'b0010;
            4'b1100: w_dpctl = 4'b0011;
            default: w_dpctl = 4'b0000;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Architectural flags load from the ALU during an executing S-instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_flags <= 4'b0000;
        else if (w_flag_we) r_flags <= ALUFlags;
    end

    // FPU wait counter: cleared on launch, counts cycles spent waiting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     r_fpcnt <= 8'd0;
        else if (r_state == S_FPSTART)  r_fpcnt <= 8'd0;
        else if (r_state == S_FPWAIT)   r_fpcnt <= r_fpcnt + 8'd1;
    end

    // Next-state and control outputs; write enables squashed when the condition fails
    always_comb begin
        w_next        = r_state;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        WE4           = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        ImmSrc        = 2'b00;
        RegSrc        = 2'b00;
        ALUControl    = 4'b0000;
        FPControl     = 2'b00;
        ResultControl = 1'b0;
        NewSource     = 1'b0;
        IsMul         = 1'b0;
        fp_start      = 1'b0;
        fp_err        = 1'b0;

        if (r_state != S_IDLE) begin
            ImmSrc = Instr[27:26];
            RegSrc = {(Instr[27:26] == 2'b01) && !Instr[20], Instr[27:26] == 2'b10};
        end

        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Instr[27:26])
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    2'b11:   w_next = S_FPSTART;
                    default: begin
                        if ((Instr[7:4] == 4'b1001) && !Instr[25]) w_next = S_MULEX;
                        else if (Instr[25])                          w_next = S_EXECI;
                        else                                         w_next = S_EXECR;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = Instr[20] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_EXECR: begin
                ALUControl = w_dpctl;
                w_next     = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_dpctl;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                PCWrite  = (Instr[15:12] == 4'b1111);
                w_next   = S_FETCH;
            end
            S_MULEX: begin
                NewSource  = 1'b1;
                ALUControl = Instr[23] ? 4'b0101 : 4'b0100;
                w_next     = S_MULWB;
            end
            S_MULWB: begin
                NewSource = 1'b1;
                RegWrite  = 1'b1;
                IsMul     = ~Instr[23];
                WE4       = Instr[23];
                w_next    = S_FETCH;
            end
            S_FPSTART: begin
                fp_start  = 1'b1;
                FPControl = Instr[21:20];
                w_next    = S_FPWAIT;
            end
            S_FPWAIT: begin
                FPControl     = Instr[21:20];
                ResultControl = 1'b1;
                if (fp_done) begin
                    w_next = S_FPWB;
                end else if (w_fp_hit) begin
                    fp_err = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_FPWB: begin
                FPControl     = Instr[21:20];
                ResultControl = 1'b1;
                RegWrite      = 1'b1;
                w_next        = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase

        if (!w_condex) begin
            RegWrite = 1'b0;
            WE4      = 1'b0;
            MemWrite = 1'b0;
            fp_start = 1'b0;
            if (r_state != S_FETCH) PCWrite = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Scoreboard bench for mc_controller. Stimulus pushes the
//               expected control vector for each cycle; a monitor pops and
//               compares on the falling edge. Expectations for the optional
//               macro COND_EXEC_EN are selected with the same macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Instr = 32'h0;
    logic [3:0]  ALUFlags = 4'h0;
    logic        fp_done = 1'b0;

    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, WE4, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, FPControl;
    logic [3:0]  ALUControl, Flags;
    logic        ResultControl, NewSource, IsMul, fp_start, fp_err;

    mc_controller #(.FP_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .fp_done(fp_done),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .WE4(WE4), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .FPControl(FPControl), .ResultControl(ResultControl), .NewSource(NewSource),
        .IsMul(IsMul), .fp_start(fp_start), .fp_err(fp_err), .Flags(Flags)
    );

    always #5 clk = ~clk;

    // Packed view of all outputs, MSB first in port order
    logic [29:0] got;
    assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, WE4, ALUSrcA, ALUSrcB,
                  ResultSrc, ImmSrc, RegSrc, ALUControl, FPControl, ResultControl,
                  NewSource, IsMul, fp_start, fp_err, Flags};

    localparam logic [29:0] B_PCW = 30'd1 << 29;
    localparam logic [29:0] B_ADR = 30'd1 << 28;
    localparam logic [29:0] B_MW  = 30'd1 << 27;
    localparam logic [29:0] B_IRW = 30'd1 << 26;
    localparam logic [29:0] B_RW  = 30'd1 << 25;
    localparam logic [29:0] B_WE4 = 30'd1 << 24;
    localparam logic [29:0] B_ASA = 30'd1 << 23;
    localparam logic [29:0] B_RC  = 30'd1 << 8;
    localparam logic [29:0] B_NS  = 30'd1 << 7;
    localparam logic [29:0] B_ISM = 30'd1 << 6;
    localparam logic [29:0] B_FPS = 30'd1 << 5;
    localparam logic [29:0] B_FPE = 30'd1 << 4;

`ifdef COND_EXEC_EN
    localparam logic [3:0]  FL_B   = 4'h9;
    localparam logic [29:0] BNE_PC = 30'd0;
    localparam logic [29:0] ORR_WB = 30'd0;
`else
    localparam logic [3:0]  FL_B   = 4'h6;
    localparam logic [29:0] BNE_PC = B_PCW;
    localparam logic [29:0] ORR_WB = B_RW;
`endif

    function automatic logic [29:0] asb(input logic [1:0] x); return 30'(x) << 21; endfunction
    function automatic logic [29:0] rs(input logic [1:0] x);  return 30'(x) << 19; endfunction
    function automatic logic [29:0] al(input logic [3:0] x);  return 30'(x) << 11; endfunction
    function automatic logic [29:0] fc(input logic [1:0] x);  return 30'(x) << 9;  endfunction
    // ImmSrc, RegSrc and Flags context of the current instruction
    function automatic logic [29:0] cx(input logic [1:0] i, input logic [1:0] r, input logic [3:0] f);
        return (30'(i) << 17) | (30'(r) << 15) | 30'(f);
    endfunction

    localparam logic [29:0] FET = B_PCW | B_IRW | B_ASA | (30'd2 << 21) | (30'd2 << 19);
    localparam logic [29:0] DEC = B_ASA | (30'd2 << 21) | (30'd2 << 19);

    typedef struct {
        string       nm;
        logic [29:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: compare each presented cycle against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL %s: got=%h expected=%h", e.nm, got, e.v);
            end
        end
    end

    task automatic cyc(input string nm, input logic [29:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        Instr = 32'hE5812004;
        ALUFlags = 4'h4;
        @(posedge clk);
        #1;
        cyc("reset0", 30'd0);
        cyc("reset1", 30'd0);
        reset = 1'b1;
        cyc("idle", 30'd0);

        // SUBS R1,R2,R3 with ALU reporting Z
        Instr = 32'hE0521003;
        cyc("subs_fetch", FET | cx(2'd0, 2'd0, 4'h0));
        cyc("subs_decode", DEC | cx(2'd0, 2'd0, 4'h0));
        cyc("subs_execr", al(4'd1) | cx(2'd0, 2'd0, 4'h0));
        ALUFlags = 4'h0;
        cyc("subs_aluwb", B_RW | cx(2'd0, 2'd0, 4'h4));

        // BEQ taken with Z set
        Instr = 32'h0A000002;
        cyc("beq_fetch", FET | cx(2'd2, 2'd1, 4'h4));
        cyc("beq_decode", DEC | cx(2'd2, 2'd1, 4'h4));
        cyc("beq_branch", B_PCW | asb(2'd1) | rs(2'd2) | cx(2'd2, 2'd1, 4'h4));

        // BNE with Z set
        Instr = 32'h1A000002;
        cyc("bne_fetch", FET | cx(2'd2, 2'd1, 4'h4));
        cyc("bne_decode", DEC | cx(2'd2, 2'd1, 4'h4));
        cyc("bne_branch", BNE_PC | asb(2'd1) | rs(2'd2) | cx(2'd2, 2'd1, 4'h4));

        // UMULL: both write ports in MULWB
        Instr = 32'hE0832291;
        cyc("umull_fetch", FET | cx(2'd0, 2'd0, 4'h4));
        cyc("umull_decode", DEC | cx(2'd0, 2'd0, 4'h4));
        cyc("umull_mulex", B_NS | al(4'd5) | cx(2'd0, 2'd0, 4'h4));
        cyc("umull_mulwb", B_NS | B_RW | B_WE4 | cx(2'd0, 2'd0, 4'h4));

        // MUL: single write addressed by Instr[19:16]
        Instr = 32'hE0030291;
        cyc("mul_fetch", FET | cx(2'd0, 2'd0, 4'h4));
        cyc("mul_decode", DEC | cx(2'd0, 2'd0, 4'h4));
        cyc("mul_mulex", B_NS | al(4'd4) | cx(2'd0, 2'd0, 4'h4));
        cyc("mul_mulwb", B_NS | B_RW | B_ISM | cx(2'd0, 2'd0, 4'h4));

        // ADDS PC,PC,#4: immediate path, PC write-back, flags to N,V
        Instr = 32'hE29FF004;
        ALUFlags = 4'h9;
        cyc("adds_fetch", FET | cx(2'd0, 2'd0, 4'h4));
        cyc("adds_decode", DEC | cx(2'd0, 2'd0, 4'h4));
        cyc("adds_execi", asb(2'd1) | cx(2'd0, 2'd0, 4'h4));
        cyc("adds_aluwb", B_RW | B_PCW | cx(2'd0, 2'd0, 4'h9));

        // ORRSLT with N=V (LT fails when conditional execution is enabled)
        Instr = 32'hB1912003;
        ALUFlags = 4'h6;
        cyc("orr_fetch", FET | cx(2'd0, 2'd0, 4'h9));
        cyc("orr_decode", DEC | cx(2'd0, 2'd0, 4'h9));
        cyc("orr_execr", al(4'd3) | cx(2'd0, 2'd0, 4'h9));
        ALUFlags = 4'h0;
        cyc("orr_aluwb", ORR_WB | cx(2'd0, 2'd0, FL_B));

        // LDR
        Instr = 32'hE5912004;
        cyc("ldr_fetch", FET | cx(2'd1, 2'd0, FL_B));
        cyc("ldr_decode", DEC | cx(2'd1, 2'd0, FL_B));
        cyc("ldr_memadr", asb(2'd1) | cx(2'd1, 2'd0, FL_B));
        cyc("ldr_memrd", B_ADR | cx(2'd1, 2'd0, FL_B));
        cyc("ldr_memwb", B_RW | rs(2'd1) | cx(2'd1, 2'd0, FL_B));

        // STR
        Instr = 32'hE5812004;
        cyc("str_fetch", FET | cx(2'd1, 2'd2, FL_B));
        cyc("str_decode", DEC | cx(2'd1, 2'd2, FL_B));
        cyc("str_memadr", asb(2'd1) | cx(2'd1, 2'd2, FL_B));
        cyc("str_memwr", B_ADR | B_MW | cx(2'd1, 2'd2, FL_B));

        // FP op, fp_done on the third wait cycle; stray done in FETCH ignored
        Instr = 32'hEC312000;
        fp_done = 1'b1;
        cyc("fp_fetch", FET | cx(2'd3, 2'd0, FL_B));
        fp_done = 1'b0;
        cyc("fp_decode", DEC | cx(2'd3, 2'd0, FL_B));
        cyc("fp_start", B_FPS | fc(2'd3) | cx(2'd3, 2'd0, FL_B));
        cyc("fp_wait1", B_RC | fc(2'd3) | cx(2'd3, 2'd0, FL_B));
        cyc("fp_wait2", B_RC | fc(2'd3) | cx(2'd3, 2'd0, FL_B));
        fp_done = 1'b1;
        cyc("fp_wait3", B_RC | fc(2'd3) | cx(2'd3, 2'd0, FL_B));
        fp_done = 1'b0;
        cyc("fp_wb", B_RC | B_RW | fc(2'd3) | cx(2'd3, 2'd0, FL_B));

        // FP timeout: fp_err on the 16th wait cycle, no write-back
        cyc("fpto_fetch", FET | cx(2'd3, 2'd0, FL_B));
        cyc("fpto_decode", DEC | cx(2'd3, 2'd0, FL_B));
        cyc("fpto_start", B_FPS | fc(2'd3) | cx(2'd3, 2'd0, FL_B));
        for (int k = 1; k <= 15; k++)
            cyc($sformatf("fpto_wait%0d", k), B_RC | fc(2'd3) | cx(2'd3, 2'd0, FL_B));
        cyc("fpto_err", B_RC | B_FPE | fc(2'd3) | cx(2'd3, 2'd0, FL_B));

        // fp_done coinciding with the timeout cycle: done wins
        cyc("fpdw_fetch", FET | cx(2'd3, 2'd0, FL_B));
        cyc("fpdw_decode", DEC | cx(2'd3, 2'd0, FL_B));
        cyc("fpdw_start", B_FPS | fc(2'd3) | cx(2'd3, 2'd0, FL_B));
        for (int k = 1; k <= 15; k++)
            cyc($sformatf("fpdw_wait%0d", k), B_RC | fc(2'd3) | cx(2'd3, 2'd0, FL_B));
        fp_done = 1'b1;
        cyc("fpdw_wait16", B_RC | fc(2'd3) | cx(2'd3, 2'd0, FL_B));
        fp_done = 1'b0;
        cyc("fpdw_wb", B_RC | B_RW | fc(2'd3) | cx(2'd3, 2'd0, FL_B));

        // LDR aborted by reset right after entering MEMRD
        Instr = 32'hE5912004;
        cyc("ldra_fetch", FET | cx(2'd1, 2'd0, FL_B));
        cyc("ldra_decode", DEC | cx(2'd1, 2'd0, FL_B));
        cyc("ldra_memadr", asb(2'd1) | cx(2'd1, 2'd0, FL_B));
        reset = 1'b0;
        cyc("ldra_abort", 30'd0);
        cyc("ldra_hold", 30'd0);
        reset = 1'b1;
        cyc("ldra_idle", 30'd0);
        Instr = 32'hE0521003;
        cyc("post_fetch", FET | cx(2'd0, 2'd0, 4'h0));

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle main controller for the ARM-subset datapath (ALU with 2-result multiply, FPU, dual-write-port regfile).
- Sequences fetch, decode, execute and writeback over several cycles per instruction.
- Evaluates condition codes against an internal flag register.
- Sequences multi-cycle FPU operations through a start/done handshake with a timeout.

Parameters:
FP_TIMEOUT, 16, max cycles in FPWAIT before abort (1..255)

Ports:
clk  input  1  clock; all flops rising-edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
Instr  input  32  instruction register contents
ALUFlags  input  4  {N,Z,C,V} from ALU, valid in execute states
fp_done  input  1  FPU result valid, single-cycle pulse
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select (0 = PC, 1 = ALU result)
MemWrite  output  1  data memory write
IRWrite  output  1  instruction register enable
RegWrite  output  1  regfile write port 3 enable
WE4  output  1  regfile write port 4 enable (RdHi of UMULL)
ALUSrcA  output  1  0 = register, 1 = PC
ALUSrcB  output  2  00 = register, 01 = ExtImm, 10 = constant 4
ResultSrc  output  2  00 = ALU/FP result, 01 = ReadData, 10 = ALU direct
ImmSrc  output  2  = Instr[27:26]
RegSrc  output  2  {STR, Branch}
ALUControl  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 MUL, 0101 UMULL
FPControl  output  2  = Instr[21:20] in FP states, else 00
ResultControl  output  1  1 = select FPU result
NewSource  output  1  1 = multiply operand addressing
IsMul  output  1  1 = write address from Instr[19:16]
fp_start  output  1  one-cycle FPU launch pulse
fp_err  output  1  one-cycle pulse on FP timeout
Flags  output  4  architectural {N,Z,C,V}

Behaviour:
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, MULEX, MULWB, FPSTART, FPWAIT, FPWB, BRANCH.
- Reset (async, reset = 0): state = IDLE, Flags = 0000, FP counter = 0. All outputs are 0 while in reset and in IDLE. IDLE always advances to FETCH on the next clk.
- FETCH: IRWrite = 1, AdrSrc = 0, ALUSrcA = 1, ALUSrcB = 10, ALUControl = ADD, ResultSrc = 10, PCWrite = 1. Next state is DECODE.
- DECODE: ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10 (computes PC+8). Next state by instruction class:
  - Instr[27:26] = 01 → MEMADR
  - Instr[27:26] = 10 → BRANCH
  - Instr[27:26] = 11 → FPSTART
  - Instr[27:26] = 00 and Instr[7:4] = 1001 and Instr[25] = 0 → MULEX
  - else Instr[25] ? EXECI : EXECR
- CondEx is computed combinationally from Instr[31:28] and Flags using the standard ARM table (EQ … AL). Cond = 1111 is treated as AL.
- If CondEx = 0, these are forced to 0: RegWrite, WE4, MemWrite, PCWrite (except in FETCH), fp_start. The instruction still walks its state path, so latency is unchanged.
- Memory path:
  - MEMADR: ALUSrcB = 01, ADD. Instr[20] ? MEMRD : MEMWR.
  - MEMRD: AdrSrc = 1 → MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite → FETCH.
  - MEMWR: AdrSrc = 1, MemWrite → FETCH.
- Data-processing path: ALUControl from Instr[24:21] (0100 ADD, 0010 SUB, 0000 AND, 1100 ORR); other opcodes use ADD.
  - EXECR/EXECI → ALUWB.
  - ALUWB: RegWrite, ResultSrc = 00.
  - Flags load ALUFlags in the EXECR/EXECI cycle when Instr[20] = 1 and CondEx.
  - PC write-back: Rd = 1111 also asserts PCWrite.
- Multiply path:
  - MULEX: NewSource = 1, ALUControl = MUL, or UMULL if Instr[23]. → MULWB.
  - MULWB: NewSource = 1, RegWrite.
  - MUL: IsMul = 1, writes Rd = Instr[19:16].
  - UMULL: IsMul = 0 (RdLo = Instr[15:12]) and WE4 = 1 (RdHi = Instr[19:16]). Both writes happen in the same cycle.
- FP path:
  - FPSTART: fp_start = 1, counter cleared → FPWAIT.
  - FPWAIT: holds FPControl/ResultControl = 1. Counter increments each cycle.
    - fp_done → FPWB.
    - Counter reaches FP_TIMEOUT with no fp_done → fp_err pulse, no write, → FETCH.
    - fp_done in the same cycle as the counter reaching FP_TIMEOUT: done wins.
  - FPWB: ResultControl = 1, RegWrite → FETCH.
  - fp_done outside FPWAIT is ignored.
- BRANCH: ALUSrcB = 01, ADD, ResultSrc = 10, PCWrite = CondEx → FETCH.
- Latency in cycles (incl. fetch):
  - Branch: 3
  - STR: 4
  - LDR: 5
  - DP: 4
  - MUL/UMULL: 4
  - FP: 4 + wait
- Reset asserted mid-instruction aborts immediately. No writes occur after assertion.

Optional Feature:
COND_EXEC_EN
- Defined: CondEx behaves as described above.
- Undefined: CondEx is tied to 1; Instr[31:28] is ignored and the flag register still updates.

Test Plan:
- Release reset → IDLE one cycle, then FETCH with IRWrite = 1, PCWrite = 1. Flags = 0000 and all other outputs 0 during reset.
- SUBS R1,R2,R3 (E0521003) with ALUFlags = 0100 → DECODE, EXECR (Flags = 0100), ALUWB RegWrite = 1. A following BEQ asserts PCWrite in BRANCH.
- BNE (1A000002) with Flags Z = 1 → BRANCH with PCWrite = 0, back to FETCH. Under !COND_EXEC_EN, PCWrite = 1.
- UMULL (E0832291) → MULEX with ALUControl = 0101, then MULWB with RegWrite = 1, WE4 = 1, IsMul = 0, NewSource = 1.
- FP op: fp_done at cycle 3 of FPWAIT → FPWB RegWrite = 1, ResultControl = 1. With fp_done never asserted: fp_err pulse after 16 cycles, no RegWrite.
- LDR (E5912004), reset deasserted-asserted during MEMRD → state IDLE immediately, RegWrite never asserted.
